// File: rtl/ppu_pkg.sv
// ppu_pkg: mode encodings, frame FSM states and small helpers shared by the
// pixel processing unit scheduler files.
package ppu_pkg;

    typedef enum logic [2:0] {
        MODE_PASS      = 3'd0,
        MODE_MASK      = 3'd1,
        MODE_DIAG      = 3'd2,
        MODE_XOR7      = 3'd3,
        MODE_XOR7_ANIM = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN
    } state_e;

    localparam int TBL_DEPTH = 8;

    // Counter width for a count of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ppu_arb2.sv
// ppu_arb2: two-way round-robin strobe/ack arbiter that registers the
// winning byte onto the ppu input port and returns a one-cycle ack.
module ppu_arb2
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s0_data,
    input  logic       s0_stb,
    input  logic [7:0] s1_data,
    input  logic       s1_stb,
    input  logic       ppu_ack,
    output logic [7:0] ppu_data,
    output logic       ppu_stb,
    output logic       s0_ack,
    output logic       s1_ack
);

    logic prio;
    logic gnt;
    logic req0;
    logic req1;
    logic pick;

    // A requester whose ack is showing still holds its old strobe, so it is
    // masked until the strobe is sampled again.
    always_comb begin
        req0 = s0_stb && !s0_ack;
        req1 = s1_stb && !s1_ack;
        pick = req1 && (!req0 || prio);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio     <= 1'b0;
            gnt      <= 1'b0;
            ppu_data <= '0;
            ppu_stb  <= 1'b0;
            s0_ack   <= 1'b0;
            s1_ack   <= 1'b0;
        end else begin
            s0_ack <= 1'b0;
            s1_ack <= 1'b0;
            if (!ppu_stb) begin
                if (req0 || req1) begin
                    gnt      <= pick;
                    ppu_data <= pick ? s1_data : s0_data;
                    ppu_stb  <= 1'b1;
                end
            end else if (ppu_ack) begin
                ppu_stb <= 1'b0;
                s0_ack  <= !gnt;
                s1_ack  <= gnt;
                prio    <= !gnt;
            end
        end
    end

endmodule

// File: rtl/ppu_sched.sv
// ppu_sched: shares the ppu input port between stream and host, paces ppu
// output pixels into frames and steps ppu_mode through a programmable table.
module ppu_sched #(
    parameter int H_PIX           = 32,
    parameter int V_LINES         = 32,
    parameter int FRAMES_PER_MODE = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [2:0] cfg_mode,
    input  logic [2:0] cfg_last,
    input  logic [7:0] s0_data,
    input  logic       s0_stb,
    input  logic [7:0] s1_data,
    input  logic       s1_stb,
    output logic       s0_ack,
    output logic       s1_ack,
    output logic [7:0] ppu_data,
    output logic       ppu_stb,
    input  logic       ppu_ack,
    input  logic       pix_stb,
    output logic       pix_ack,
    input  logic       pix_ready,
    output logic       ppu_sync,
    output logic [2:0] ppu_mode,
    output logic       frame_done,
    output logic [2:0] cur_idx
);
    import ppu_pkg::*;

    localparam int HW = cnt_width(H_PIX);
    localparam int VW = cnt_width(V_LINES);
    localparam int FW = cnt_width(FRAMES_PER_MODE);
    localparam logic [HW-1:0] H_LAST = HW'(H_PIX - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_LINES - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_MODE - 1);

    state_e        state;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [FW-1:0] frame_cnt;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic          mode_wrap;
    logic          last_pix;
    logic [2:0]    mode_tbl [TBL_DEPTH];

    ppu_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .s0_data  (s0_data),
        .s0_stb   (s0_stb),
        .s1_data  (s1_data),
        .s1_stb   (s1_stb),
        .ppu_ack  (ppu_ack),
        .ppu_data (ppu_data),
        .ppu_stb  (ppu_stb),
        .s0_ack   (s0_ack),
        .s1_ack   (s1_ack)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TBL_DEPTH; i++) mode_tbl[i] <= MODE_PASS;
        end else if (cfg_we) begin
            mode_tbl[cfg_addr] <= cfg_mode;
        end
    end

    always_comb begin
        mode_wrap = (frame_cnt == F_LAST);
        idx_next  = idx;
        if (mode_wrap) idx_next = (idx >= cfg_last) ? 3'd0 : idx + 3'd1;
    end

    assign cur_idx = idx;

    // The final pixel's ack is shown for a cycle before SYNC, giving the
    // one-cycle acceptance stall at every frame boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            h          <= '0;
            v          <= '0;
            frame_cnt  <= '0;
            idx        <= '0;
            last_pix   <= 1'b0;
            pix_ack    <= 1'b0;
            ppu_sync   <= 1'b0;
            frame_done <= 1'b0;
            ppu_mode   <= MODE_PASS;
        end else begin
            pix_ack    <= 1'b0;
            ppu_sync   <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state     <= SYNC;
                        idx       <= 3'd0;
                        frame_cnt <= '0;
                        ppu_mode  <= mode_tbl[0];
                        ppu_sync  <= 1'b1;
                    end
                end
                SYNC: begin
                    state <= RUN;
                    h     <= '0;
                    v     <= '0;
                end
                RUN: begin
                    if (!en) begin
                        state     <= IDLE;
                        h         <= '0;
                        v         <= '0;
                        frame_cnt <= '0;
                        last_pix  <= 1'b0;
                    end else if (last_pix) begin
                        state      <= SYNC;
                        last_pix   <= 1'b0;
                        ppu_sync   <= 1'b1;
                        frame_done <= 1'b1;
                        idx        <= idx_next;
                        ppu_mode   <= mode_tbl[idx_next];
                        frame_cnt  <= mode_wrap ? '0 : frame_cnt + 1'b1;
                    end else if (pix_stb && pix_ready && !pix_ack) begin
                        pix_ack <= 1'b1;
                        if (h == H_LAST) begin
                            h <= '0;
                            if (v == V_LAST) begin
                                v        <= '0;
                                last_pix <= 1'b1;
                            end else begin
                                v <= v + 1'b1;
                            end
                        end else begin
                            h <= h + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_sched.sv
// tb_ppu_sched: directed stimulus with scoreboard queues for arbiter acks and
// frame syncs, checked by a negedge monitor.
`timescale 1ns/1ps
module tb_ppu_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [2:0] cfg_mode = '0;
    logic [2:0] cfg_last = '0;
    logic [7:0] s0_data = '0;
    logic       s0_stb = 1'b0;
    logic [7:0] s1_data = '0;
    logic       s1_stb = 1'b0;
    logic       s0_ack;
    logic       s1_ack;
    logic [7:0] ppu_data;
    logic       ppu_stb;
    logic       ppu_ack = 1'b0;
    logic       pix_stb = 1'b0;
    logic       pix_ack;
    logic       pix_ready = 1'b0;
    logic       ppu_sync;
    logic [2:0] ppu_mode;
    logic       frame_done;
    logic [2:0] cur_idx;

    typedef struct {
        logic       src;
        logic [7:0] data;
    } arb_item_t;

    typedef struct {
        logic [2:0] mode;
        logic [2:0] idx;
        logic       done;
        int         npix;
        int         gap;
    } sync_item_t;

    arb_item_t  arb_exp[$];
    sync_item_t sync_exp[$];
    logic [7:0] pend0[$];
    logic [7:0] pend1[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int pix_total = 0;
    int sync_seen = 0;

    initial forever #5 clk = ~clk;

    ppu_sched #(.H_PIX(4), .V_LINES(2), .FRAMES_PER_MODE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_mode   (cfg_mode),
        .cfg_last   (cfg_last),
        .s0_data    (s0_data),
        .s0_stb     (s0_stb),
        .s1_data    (s1_data),
        .s1_stb     (s1_stb),
        .s0_ack     (s0_ack),
        .s1_ack     (s1_ack),
        .ppu_data   (ppu_data),
        .ppu_stb    (ppu_stb),
        .ppu_ack    (ppu_ack),
        .pix_stb    (pix_stb),
        .pix_ack    (pix_ack),
        .pix_ready  (pix_ready),
        .ppu_sync   (ppu_sync),
        .ppu_mode   (ppu_mode),
        .frame_done (frame_done),
        .cur_idx    (cur_idx)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic ps, input logic pr);
        en        = e;
        pix_stb   = ps;
        pix_ready = pr;
    endtask

    task automatic writeTable(input logic [2:0] a, input logic [2:0] m);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_mode = m;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pushSync(input logic [2:0] m, input logic [2:0] i, input logic d, input int np, input int g);
        sync_item_t s;
        s.mode = m; s.idx = i; s.done = d; s.npix = np; s.gap = g;
        sync_exp.push_back(s);
    endtask

    task automatic pushReq(input logic src, input logic [7:0] d);
        if (src) pend1.push_back(d);
        else pend0.push_back(d);
    endtask

    task automatic expectAck(input logic src, input logic [7:0] d);
        arb_item_t e;
        e.src = src; e.data = d;
        arb_exp.push_back(e);
    endtask

    task automatic timeoutFail(input string name, input int got, input int want);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got %0d, expected %0d before cycle budget ran out", name, got, want);
    endtask

    task automatic waitSyncs(input int target, input int budget);
        int n = 0;
        while (sync_seen < target && n < budget) begin tick(); n++; end
        if (sync_seen < target) timeoutFail("wait_sync", sync_seen, target);
    endtask

    task automatic waitAcks(input int cnt, input int budget);
        int base = pix_total;
        int n = 0;
        while (pix_total < base + cnt && n < budget) begin tick(); n++; end
        if (pix_total < base + cnt) timeoutFail("wait_pix_ack", pix_total - base, cnt);
    endtask

    task automatic waitArbEmpty(input int budget);
        int n = 0;
        while (arb_exp.size() > 0 && n < budget) begin tick(); n++; end
        if (arb_exp.size() > 0) timeoutFail("wait_arb", arb_exp.size(), 0);
        repeat (2) tick();
    endtask

    // Requesters hold their strobe until acked; the ppu acks one cycle
    // after it has seen ppu_stb for a full cycle.
    initial begin : requesters
        logic stb_d;
        stb_d = 1'b0;
        forever begin
            tick();
            ppu_ack = ppu_stb && stb_d && !ppu_ack;
            stb_d   = ppu_stb;
            if (s0_ack) s0_stb = 1'b0;
            else if (!s0_stb && pend0.size() > 0) begin s0_data = pend0.pop_front(); s0_stb = 1'b1; end
            if (s1_ack) s1_stb = 1'b0;
            else if (!s1_stb && pend1.size() > 0) begin s1_data = pend1.pop_front(); s1_stb = 1'b1; end
        end
    end

    initial begin : monitor
        arb_item_t  e;
        sync_item_t s;
        logic [7:0] cap_data;
        logic       prev_stb, prev_a0, prev_a1;
        int         stb_rise, npix, last_sync;
        cap_data = '0; prev_stb = 1'b0; prev_a0 = 1'b0; prev_a1 = 1'b0;
        stb_rise = 0; npix = 0; last_sync = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_stb = 1'b0; prev_a0 = 1'b0; prev_a1 = 1'b0;
            end else begin
                if (ppu_stb && !prev_stb) stb_rise = cyc;
                if (ppu_stb && ppu_ack) cap_data = ppu_data;
                if (s0_ack) checkOutput("s0_ack_pulse", prev_a0, 0);
                if (s1_ack) checkOutput("s1_ack_pulse", prev_a1, 0);
                if (s0_ack || s1_ack) begin
                    if (arb_exp.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL arb_extra_ack: got s0_ack=%b s1_ack=%b, expected no ack", s0_ack, s1_ack);
                    end else begin
                        e = arb_exp.pop_front();
                        checkOutput("ack_src", {30'd0, s1_ack, s0_ack}, e.src ? 32'd2 : 32'd1);
                        checkOutput("ack_data", cap_data, e.data);
                        checkOutput("ack_latency", cyc - stb_rise, 2);
                    end
                end
                prev_stb = ppu_stb; prev_a0 = s0_ack; prev_a1 = s1_ack;

                if (pix_ack) begin pix_total++; npix++; end
                if (frame_done) checkOutput("done_with_sync", ppu_sync, 1);
                if (ppu_sync) begin
                    if (sync_exp.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL sync_extra: got ppu_sync=1 mode=%0d, expected no sync", ppu_mode);
                    end else begin
                        s = sync_exp.pop_front();
                        checkOutput("sync_mode", ppu_mode, s.mode);
                        checkOutput("sync_idx", cur_idx, s.idx);
                        checkOutput("sync_done", frame_done, s.done);
                        if (s.npix >= 0) checkOutput("frame_pixels", npix, s.npix);
                        if (s.gap > 0) checkOutput("sync_gap", cyc - last_sync, s.gap);
                    end
                    npix = 0;
                    last_sync = cyc;
                    sync_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int base;
        int n;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ppu_stb", ppu_stb, 0);
        checkOutput("rst_s0_ack", s0_ack, 0);
        checkOutput("rst_s1_ack", s1_ack, 0);
        checkOutput("rst_ppu_data", ppu_data, 0);
        checkOutput("rst_pix_ack", pix_ack, 0);
        checkOutput("rst_ppu_sync", ppu_sync, 0);
        checkOutput("rst_ppu_mode", ppu_mode, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_cur_idx", cur_idx, 0);
        rst = 1'b1;
        tick();

        writeTable(3'd0, 3'd1);
        writeTable(3'd1, 3'd3);
        writeTable(3'd2, 3'd4);
        cfg_last = 3'd2;

        $display("[TB] arbiter: simultaneous strobes");
        expectAck(1'b0, 8'hA5); expectAck(1'b1, 8'h3C);
        pushReq(1'b0, 8'hA5); pushReq(1'b1, 8'h3C);
        waitArbEmpty(50);
        expectAck(1'b0, 8'h11); expectAck(1'b1, 8'h22);
        pushReq(1'b0, 8'h11); pushReq(1'b1, 8'h22);
        waitArbEmpty(50);
        expectAck(1'b0, 8'h55);
        pushReq(1'b0, 8'h55);
        waitArbEmpty(50);
        expectAck(1'b1, 8'h77); expectAck(1'b0, 8'h66);
        pushReq(1'b0, 8'h66); pushReq(1'b1, 8'h77);
        waitArbEmpty(50);
        expectAck(1'b0, 8'h88); expectAck(1'b0, 8'h99);
        pushReq(1'b0, 8'h88); pushReq(1'b0, 8'h99);
        waitArbEmpty(50);

        $display("[TB] frame pacing and mode sequence");
        pushSync(3'd1, 3'd0, 1'b0, -1, -1);
        pushSync(3'd1, 3'd0, 1'b1, 8, 17);
        pushSync(3'd3, 3'd1, 1'b1, 8, 17);
        pushSync(3'd3, 3'd1, 1'b1, 8, 17);
        pushSync(3'd4, 3'd2, 1'b1, 8, 17);
        pushSync(3'd4, 3'd2, 1'b1, 8, 17);
        pushSync(3'd1, 3'd0, 1'b1, 8, 17);
        pushSync(3'd1, 3'd0, 1'b1, 8, 27);
        pushSync(3'd6, 3'd1, 1'b1, 8, 17);
        pushSync(3'd5, 3'd0, 1'b0, -1, -1);
        pushSync(3'd5, 3'd0, 1'b1, 8, 17);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitSyncs(7, 300);

        $display("[TB] backpressure mid-line");
        waitAcks(2, 20);
        applyStimulus(1'b1, 1'b1, 1'b0);
        base = pix_total;
        repeat (10) tick();
        checkOutput("stall_pix_ack", pix_total - base, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitSyncs(8, 100);

        $display("[TB] table writes during a frame");
        writeTable(3'd0, 3'd5);
        writeTable(3'd1, 3'd6);
        tick();
        checkOutput("active_mode_hold", ppu_mode, 1);
        checkOutput("active_idx_hold", cur_idx, 0);
        waitSyncs(9, 100);

        $display("[TB] enable dropped mid-frame");
        waitAcks(3, 20);
        applyStimulus(1'b0, 1'b1, 1'b1);
        base = pix_total;
        repeat (6) tick();
        checkOutput("idle_pix_ack", pix_total - base, 0);
        checkOutput("idle_ppu_sync", ppu_sync, 0);
        checkOutput("idle_mode_hold", ppu_mode, 6);
        applyStimulus(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("sync_after_en", ppu_sync, 1);
        checkOutput("done_after_en", frame_done, 0);
        waitSyncs(11, 100);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        $display("[TB] reset during a transaction");
        expectAck(1'b1, 8'h5A);
        pushReq(1'b1, 8'h5A);
        n = 0;
        while (!ppu_stb && n < 20) begin tick(); n++; end
        if (!ppu_stb) timeoutFail("wait_ppu_stb", 0, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid_rst_ppu_stb", ppu_stb, 0);
        checkOutput("mid_rst_ppu_data", ppu_data, 0);
        checkOutput("mid_rst_s1_ack", s1_ack, 0);
        checkOutput("mid_rst_ppu_mode", ppu_mode, 0);
        checkOutput("mid_rst_cur_idx", cur_idx, 0);
        repeat (2) tick();
        #3 rst = 1'b1;
        waitArbEmpty(30);
        repeat (10) tick();

        checkOutput("arb_left", arb_exp.size(), 0);
        checkOutput("sync_left", sync_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
